// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, digit masks,
// the BCD digit type and small helpers used by the timer display.
package seg7_pkg;

  // Mask bit positions, packed as {a,b,c,d,e,f,g}
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [9:0][6:0] DIGIT_MASK = {
    7'h7B,  // 9 abcdfg
    7'h7F,  // 8 all
    7'h70,  // 7 abc
    7'h5F,  // 6 acdefg
    7'h5B,  // 5 acdfg
    7'h33,  // 4 bcfg
    7'h79,  // 3 abcdg
    7'h6D,  // 2 abdeg
    7'h30,  // 1 bc
    7'h7E   // 0 abcdef
  };

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_timer_display_if.sv
// Control, preload, pixel-coordinate and status signals of the BCD timer display.
interface bcd_timer_display_if #(parameter int DIGITS = 3);
  logic                  i_run;
  logic                  i_down;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_val;
  logic [9:0]            i_x;
  logic [9:0]            i_y;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_pix;
  logic                  o_wrap;
  logic                  o_zero;

  modport master (
    output i_run, i_down, i_load, i_load_val, i_x, i_y,
    input  o_bcd, o_pix, o_wrap, o_zero
  );

  modport slave (
    input  i_run, i_down, i_load, i_load_val, i_x, i_y,
    output o_bcd, o_pix, o_wrap, o_zero
  );
endinterface

// File: rtl/bcd_seg_decode.sv
// One BCD digit to its abcdefg segment mask; non-decimal codes light nothing.
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  bcd_digit_t  i_digit,
  output logic [6:0]  o_mask
);
  always_comb begin
    o_mask = '0;
    if (i_digit <= 4'd9) o_mask = DIGIT_MASK[i_digit];
  end
endmodule

// File: rtl/bcd_timer_display.sv
// BCD up/down seconds timer with prescaler, preload, zero saturation and a
// registered "pixel on lit segment" flag for the on-screen seven-segment digits.
module bcd_timer_display
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int DIV     = 50_000_000,
  parameter int X0      = 535,
  parameter int Y0      = 50,
  parameter int SEG_LEN = 25,
  parameter int PITCH   = 35,
  parameter int THICK   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bcd_timer_display_if.slave bus
);
  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PS_MAX = PW'(DIV - 1);

  // Index 0 is the least significant digit; it maps to the bottom nibble of o_bcd.
  logic [DIGITS-1:0][3:0] bcd_q, bcd_d, load_clamped, inc_v, dec_v;
  logic [PW-1:0]          ps_q, ps_d;
  logic                   wrap_q, wrap_d, zero_q, zero_d, pix_q, pix_d;
  logic                   tick, carry, borrow, is_zero;
  logic [DIGITS-1:0]      lit;
  logic [10:0]            x11, y11;

  assign tick = bus.i_run && (ps_q == PS_MAX);

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      load_clamped[i] = bcd_clamp(bus.i_load_val[4*i +: 4]);
  end

  // Ripple chains; a carry out of the top digit means the count was all 9s.
  always_comb begin
    inc_v = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[i] == 4'd9) inc_v[i] = 4'd0;
        else begin
          inc_v[i] = bcd_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    is_zero = (bcd_q == '0);
    dec_v   = bcd_q;
    borrow  = ~is_zero;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (bcd_q[i] == 4'd0) dec_v[i] = 4'd9;
        else begin
          dec_v[i] = bcd_q[i] - 4'd1;
          borrow   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ps_d   = ps_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (bus.i_load) begin
      bcd_d = load_clamped;
      ps_d  = '0;
    end else begin
      if (bus.i_run) ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        if (bus.i_down) bcd_d = dec_v;
        else begin
          bcd_d  = inc_v;
          wrap_d = carry;
        end
      end
    end
    zero_d = (bcd_d == '0);
  end

  assign x11 = {1'b0, bus.i_x};
  assign y11 = {1'b0, bus.i_y};

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    localparam logic [10:0] XL = 11'(X0 + k*PITCH);
    localparam logic [10:0] XR = 11'(X0 + k*PITCH + SEG_LEN);
    localparam logic [10:0] YT = 11'(Y0);
    localparam logic [10:0] YM = 11'(Y0 + SEG_LEN);
    localparam logic [10:0] YB = 11'(Y0 + 2*SEG_LEN);
    localparam logic [10:0] TW = 11'(THICK - 1);

    logic [6:0] mask, in_seg;

    // Screen digit k is the k-th from the left, i.e. packed index DIGITS-1-k.
    bcd_seg_decode u_dec (
      .i_digit (bcd_q[DIGITS-1-k]),
      .o_mask  (mask)
    );

    always_comb begin
      in_seg        = '0;
      in_seg[SEG_A] = in_rng(x11, XL, XR) && in_rng(y11, YT, YT + TW);
      in_seg[SEG_G] = in_rng(x11, XL, XR) && in_rng(y11, YM, YM + TW);
      in_seg[SEG_D] = in_rng(x11, XL, XR) && in_rng(y11, YB, YB + TW);
      in_seg[SEG_F] = in_rng(x11, XL, XL + TW) && in_rng(y11, YT, YM);
      in_seg[SEG_E] = in_rng(x11, XL, XL + TW) && in_rng(y11, YM, YB);
      in_seg[SEG_B] = in_rng(x11, XR, XR + TW) && in_rng(y11, YT, YM);
      in_seg[SEG_C] = in_rng(x11, XR, XR + TW) && in_rng(y11, YM, YB);
    end

    assign lit[k] = |(mask & in_seg);
  end

  assign pix_d = |lit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ps_q   <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      zero_q <= 1'b1;
      pix_q  <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      zero_q <= zero_d;
      pix_q  <= pix_d;
    end
  end

  assign bus.o_bcd  = bcd_q;
  assign bus.o_wrap = wrap_q;
  assign bus.o_zero = zero_q;
  assign bus.o_pix  = pix_q;
endmodule
